// File: rtl/hazard_unit_if.sv
// Pipeline-side signal bundle for the hazard unit: ID/EX/MEM hazard sources in,
// stall/flush controls and bubble-gated control fields out.
interface hazard_unit_if #(
   parameter int REG_ADDR_W = 6
);
   logic [REG_ADDR_W-1:0] IFID_RsAddr_i;
   logic [REG_ADDR_W-1:0] IFID_RtAddr_i;
   logic                  ID_UsesRt_i;
   logic                  ID_Branch_i;
   logic                  ID_BranchTaken_i;
   logic                  ID_Jump_i;
   logic                  IDEX_MemRead_i;
   logic                  IDEX_RegWrite_i;
   logic [REG_ADDR_W-1:0] IDEX_DstAddr_i;
   logic                  EXMEM_MemRead_i;
   logic [REG_ADDR_W-1:0] EXMEM_DstAddr_i;
   logic [1:0]            WB_i;
   logic [1:0]            MEM_i;
   logic [3:0]            EX_i;
   logic [1:0]            WB_o;
   logic [1:0]            MEM_o;
   logic [3:0]            EX_o;
   logic                  PC_Write_o;
   logic                  IFID_Write_o;
   logic                  IFID_Flush_o;

   // Pipeline side: drives hazard sources, consumes controls.
   modport master (
      output IFID_RsAddr_i, IFID_RtAddr_i, ID_UsesRt_i, ID_Branch_i, ID_BranchTaken_i,
             ID_Jump_i, IDEX_MemRead_i, IDEX_RegWrite_i, IDEX_DstAddr_i,
             EXMEM_MemRead_i, EXMEM_DstAddr_i, WB_i, MEM_i, EX_i,
      input  WB_o, MEM_o, EX_o, PC_Write_o, IFID_Write_o, IFID_Flush_o
   );

   // Hazard unit side.
   modport slave (
      input  IFID_RsAddr_i, IFID_RtAddr_i, ID_UsesRt_i, ID_Branch_i, ID_BranchTaken_i,
             ID_Jump_i, IDEX_MemRead_i, IDEX_RegWrite_i, IDEX_DstAddr_i,
             EXMEM_MemRead_i, EXMEM_DstAddr_i, WB_i, MEM_i, EX_i,
      output WB_o, MEM_o, EX_o, PC_Write_o, IFID_Write_o, IFID_Flush_o
   );
endinterface

// File: rtl/hazard_unit.sv
// Load-use / branch-operand hazard detection with stall, bubble and flush control,
// plus saturating stall and flush event counters.
module hazard_unit #(
   parameter int REG_ADDR_W = 6,
   parameter int CNT_W      = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   hazard_unit_if.slave     hz,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   typedef enum logic {RUN, STALL_BR} state_t;

   state_t state_q, state_nxt;
   logic   h_lu, h_bex, h_bmm;
   logic   stall, flush;

   // Register 0 is hard-wired, so it never carries a dependency.
   function automatic logic match(input logic [REG_ADDR_W-1:0] d,
                                  input logic [REG_ADDR_W-1:0] rs,
                                  input logic [REG_ADDR_W-1:0] rt,
                                  input logic                  uses_rt);
      return (d != '0) && ((d == rs) || (uses_rt && (d == rt)));
   endfunction

   assign h_lu  = hz.IDEX_MemRead_i &&
                  match(hz.IDEX_DstAddr_i, hz.IFID_RsAddr_i, hz.IFID_RtAddr_i, hz.ID_UsesRt_i);
   assign h_bex = hz.ID_Branch_i && hz.IDEX_RegWrite_i &&
                  match(hz.IDEX_DstAddr_i, hz.IFID_RsAddr_i, hz.IFID_RtAddr_i, hz.ID_UsesRt_i);
   assign h_bmm = hz.ID_Branch_i && hz.EXMEM_MemRead_i &&
                  match(hz.EXMEM_DstAddr_i, hz.IFID_RsAddr_i, hz.IFID_RtAddr_i, hz.ID_UsesRt_i);

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_nxt = state_q;
      stall     = 1'b0;
      unique case (state_q)
         RUN: begin
            stall = h_lu | h_bex | h_bmm;
            // A load feeding a branch needs a second bubble: the value arrives only after MEM.
            if (h_lu && hz.ID_Branch_i) state_nxt = STALL_BR;
         end
         STALL_BR: begin
            stall     = 1'b1;
            state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase

      // Stall wins over flush: the branch must re-resolve once its operands are fresh.
      flush = !stall && (hz.ID_BranchTaken_i || hz.ID_Jump_i);

      if (rst_i) begin
         hz.PC_Write_o   = 1'b0;
         hz.IFID_Write_o = 1'b0;
         hz.IFID_Flush_o = 1'b1;
         hz.WB_o         = '0;
         hz.MEM_o        = '0;
         hz.EX_o         = '0;
      end else begin
         hz.PC_Write_o   = !stall;
         hz.IFID_Write_o = !stall;
         hz.IFID_Flush_o = flush;
         hz.WB_o         = stall ? 2'b00   : hz.WB_i;
         hz.MEM_o        = stall ? 2'b00   : hz.MEM_i;
         hz.EX_o         = stall ? 4'b0000 : hz.EX_i;
      end
   end

   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst_i) begin
         state_q     <= RUN;
         stall_cnt_o <= '0;
         flush_cnt_o <= '0;
      end else begin
         state_q <= state_nxt;
         if (stall && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
         if (flush && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
   end

endmodule
